hy_timer_bank: RTL and testbench
================================

HY_TIMER_BANK -- requirements
Module: hy_timer_bank

Interface
REQ-001 SHALL have parameter C_WIDTH, default 8: counter and load-value width in bits.
REQ-002 SHALL have parameter CH_AW, default 2: channel address width; N_CH = 2**CH_AW channels.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tick, input, 1: global count enable, sampled each clk edge.
REQ-006 SHALL have port cfg_we, input, 1: configuration write strobe, one write per asserted cycle.
REQ-007 SHALL have port cfg_ch, input, CH_AW: target channel of the write.
REQ-008 SHALL have port cfg_load, input, C_WIDTH: terminal value for the target channel.
REQ-009 SHALL have port cfg_mode, input, 2: 00 disabled, 01 one-shot, 10 auto-reload, 11 reserved (treated as disabled).
REQ-010 SHALL have port int_clr, input, N_CH: per-channel interrupt clear, bit i clears channel i.
REQ-011 SHALL have port cnt_out, output, N_CH*C_WIDTH: channel i count on bits [i*C_WIDTH +: C_WIDTH].
REQ-012 SHALL have port int, output, N_CH: sticky per-channel terminal-count flags.
REQ-013 SHALL have port int_any, output, 1: OR of all int bits.

Function
REQ-014 SHALL keep, per channel, a load register, a mode register, a counter, an int flag and a state from {IDLE, RUN, DONE}.
REQ-015 SHALL, on cfg_we, write cfg_load and cfg_mode into channel cfg_ch, clear its counter to 0, and enter RUN for modes 01/10 or IDLE for 00/11, with the new values effective the following cycle.
REQ-016 SHALL leave the int flag unchanged on a configuration write.
REQ-017 SHALL, in RUN with tick=1 and counter != load, increment the counter by 1.
REQ-018 SHALL, in RUN with tick=1 and counter == load (terminal event), set the int flag on the same edge.
REQ-019 SHALL, on a terminal event in auto-reload, clear the counter to 0 and remain in RUN (period = load+1 ticks).
REQ-020 SHALL, on a terminal event in one-shot, hold the counter at load and enter DONE.
REQ-021 SHALL hold the counter unchanged in IDLE, in DONE, and whenever tick=0.
REQ-022 SHALL, with load = 0 in RUN, produce a terminal event on every tick (auto-reload) or on the first tick (one-shot).
REQ-023 SHALL leave DONE or IDLE only via a configuration write to that channel.
REQ-024 SHALL, when cfg_we targets a channel in the same cycle as its terminal event, apply the write and suppress that event (int not set).
REQ-025 SHALL, when int_clr[i] and a terminal event on channel i coincide, leave int[i] set (set wins).
REQ-026 SHALL clear int[i] on the edge after int_clr[i]=1 when no coincident terminal event occurs.
REQ-027 SHALL update channels independently; a write to one channel SHALL not disturb others.
REQ-028 SHALL drive cnt_out and int directly from registers, and int_any combinationally from int.
REQ-029 SHALL never let the counter exceed load or wrap through 2**C_WIDTH-1 unless load = 2**C_WIDTH-1.

Reset
REQ-030 SHALL, while rst_n=0, force every counter, load register and int flag to 0, every mode to 00, every state to IDLE, independent of clk.
REQ-031 SHALL, on rst_n deassertion, keep all outputs 0 (cnt_out=0, int=0, int_any=0) until a configuration write and ticks occur.
REQ-032 SHALL abort in-progress counting when reset is asserted mid-operation, with no int generated on release.

Verification
REQ-033 SHALL cover: reset, write ch0 load=5 mode=10, tick=1 continuous -> cnt_out[7:0] 0,1..5,0,1..; int[0] rises on the edge where count 5 -> 0, repeating every 6 cycles.
REQ-034 SHALL cover: write ch1 load=3 mode=01, tick=1 -> count 0..3, int[1]=1, state DONE, count holds 3 for 10 further ticks; int_clr[1] pulse -> int[1]=0, int_any=0.
REQ-035 SHALL cover: ch2 load=0 auto-reload with tick toggling 1,0,1,0 -> int[2] set after first tick, counter stays 0; ch3 write mode=11 -> counter stays 0, no int.
REQ-036 SHALL cover: ch0 at count 5 of load 5 with tick=1 and simultaneous cfg_we to ch0 (load=2) -> no int[0], count 0, next period 3 ticks; simultaneous int_clr[0] with terminal event -> int[0] stays 1.
REQ-037 SHALL cover: rst_n pulled low asynchronously between clk edges while ch0 counts at 3 -> cnt_out and int become 0 immediately; after release no counting until rewrite.
REQ-038 SHALL cover: C_WIDTH=4, load=15 auto-reload -> count 0..15,0 with int each 16 ticks, no overflow artefacts.

Source files
------------

// File: rtl/hy_timer_bank.sv
// Bank of N_CH independent up-counting timers with per-channel terminal value,
// one-shot / auto-reload modes and sticky terminal-count flags (intr).
module hy_timer_bank #(
  parameter int C_WIDTH = 8,
  parameter int CH_AW   = 2,
  localparam int N_CH   = 2**CH_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      cfg_we,
  input  logic [CH_AW-1:0]          cfg_ch,
  input  logic [C_WIDTH-1:0]        cfg_load,
  input  logic [1:0]                cfg_mode,
  input  logic [N_CH-1:0]           int_clr,
  output logic [N_CH*C_WIDTH-1:0]   cnt_out,
  output logic [N_CH-1:0]           intr,
  output logic                      int_any
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RELOAD  = 2'b10;

  logic [C_WIDTH-1:0] load_r  [N_CH];
  logic [C_WIDTH-1:0] load_s  [N_CH];
  logic [1:0]         mode_r  [N_CH];
  logic [1:0]         mode_s  [N_CH];
  logic [C_WIDTH-1:0] cnt_r   [N_CH];
  logic [C_WIDTH-1:0] cnt_s   [N_CH];
  state_e             state_r [N_CH];
  state_e             state_s [N_CH];
  logic               wr_s    [N_CH];
  logic               term_s  [N_CH];
  logic [N_CH-1:0]    int_r;
  logic [N_CH-1:0]    int_s;

  // Per-channel next-state: a config write overrides and suppresses any terminal event.
  always_comb begin
    int_s = int_r;
    for (int i = 0; i < N_CH; i++) begin
      load_s[i]  = load_r[i];
      mode_s[i]  = mode_r[i];
      cnt_s[i]   = cnt_r[i];
      state_s[i] = state_r[i];
      wr_s[i]    = cfg_we && (cfg_ch == CH_AW'(i));
      term_s[i]  = (state_r[i] == ST_RUN) && tick && (cnt_r[i] == load_r[i]);

      if (wr_s[i]) begin
        load_s[i] = cfg_load;
        mode_s[i] = cfg_mode;
        cnt_s[i]  = {C_WIDTH{1'b0}};
        case (cfg_mode)
          MODE_ONESHOT, MODE_RELOAD: state_s[i] = ST_RUN;
          default:                   state_s[i] = ST_IDLE;
        endcase
      end else if (term_s[i]) begin
        case (mode_r[i])
          MODE_RELOAD: begin
            cnt_s[i]   = {C_WIDTH{1'b0}};
            state_s[i] = ST_RUN;
          end
          MODE_ONESHOT: begin
            cnt_s[i]   = cnt_r[i];
            state_s[i] = ST_DONE;
          end
          default: begin
            cnt_s[i]   = cnt_r[i];
            state_s[i] = ST_IDLE;
          end
        endcase
      end else if ((state_r[i] == ST_RUN) && tick) begin
        cnt_s[i] = cnt_r[i] + C_WIDTH'(1);
      end else begin
        cnt_s[i] = cnt_r[i];
      end

      // Set has priority over clear so a coincident event is never lost.
      if (term_s[i] && !wr_s[i]) begin
        int_s[i] = 1'b1;
      end else if (int_clr[i]) begin
        int_s[i] = 1'b0;
      end else begin
        int_s[i] = int_r[i];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_r <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        load_r[i]  <= {C_WIDTH{1'b0}};
        mode_r[i]  <= 2'b00;
        cnt_r[i]   <= {C_WIDTH{1'b0}};
        state_r[i] <= ST_IDLE;
      end
    end else begin
      int_r <= int_s;
      for (int i = 0; i < N_CH; i++) begin
        load_r[i]  <= load_s[i];
        mode_r[i]  <= mode_s[i];
        cnt_r[i]   <= cnt_s[i];
        state_r[i] <= state_s[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign cnt_out[g*C_WIDTH +: C_WIDTH] = cnt_r[g];
  end

  assign intr    = int_r;
  assign int_any = |int_r;

endmodule

// File: tb/tb_hy_timer_bank.sv
// Directed self-checking bench for hy_timer_bank: default 8-bit instance plus
// a 4-bit instance for the full-range reload case.
module tb_hy_timer_bank;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_load;
  logic [1:0]  cfg_mode;
  logic [3:0]  int_clr;
  logic [31:0] cnt_out;
  logic [3:0]  intr;
  logic        int_any;

  logic        tick4;
  logic        cfg_we4;
  logic [1:0]  cfg_ch4;
  logic [3:0]  cfg_load4;
  logic [1:0]  cfg_mode4;
  logic [3:0]  int_clr4;
  logic [15:0] cnt_out4;
  logic [3:0]  intr4;
  logic        int_any4;

  int checks = 0;
  int errors = 0;

  hy_timer_bank dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .int_clr(int_clr),
    .cnt_out(cnt_out), .intr(intr), .int_any(int_any)
  );

  hy_timer_bank #(.C_WIDTH(4), .CH_AW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick4), .cfg_we(cfg_we4), .cfg_ch(cfg_ch4),
    .cfg_load(cfg_load4), .cfg_mode(cfg_mode4), .int_clr(int_clr4),
    .cnt_out(cnt_out4), .intr(intr4), .int_any(int_any4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] ld, input logic [1:0] md);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_load = ld;
    cfg_mode = md;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_load = 8'd0;
    cfg_mode = 2'b00; int_clr = 4'b0000;
    tick4 = 1'b0; cfg_we4 = 1'b0; cfg_ch4 = 2'd0; cfg_load4 = 4'd0;
    cfg_mode4 = 2'b00; int_clr4 = 4'b0000;
    #1;
    checks++; if (cnt_out !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", cnt_out); end
    checks++; if (intr !== 4'b0000) begin errors++; $display("FAIL reset_int: got %0b expected 0", intr); end
    checks++; if (int_any !== 1'b0) begin errors++; $display("FAIL reset_int_any: got %0b expected 0", int_any); end
    checks++; if (cnt_out4 !== 16'd0 || intr4 !== 4'b0000) begin errors++; $display("FAIL reset_w4: got %0h/%0b expected 0/0", cnt_out4, intr4); end
    #21;
    rst_n = 1'b1;
    tick  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (cnt_out !== 32'd0 || intr !== 4'b0000 || int_any !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: got cnt=%0h int=%0b any=%0b expected all 0", cnt_out, intr, int_any);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_autoreload();
    logic [7:0] exp_cnt;
    logic       exp_int;
    cfg_write(2'd0, 8'd5, 2'b10);
    checks++; if (cnt_out[7:0] !== 8'd0) begin errors++; $display("FAIL ar_start: got %0d expected 0", cnt_out[7:0]); end
    tick = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      int_clr = (k == 7) ? 4'b0001 : 4'b0000;
      step();
      exp_cnt = 8'(k % 6);
      exp_int = (k == 6) || (k >= 12);
      checks++; if (cnt_out[7:0] !== exp_cnt) begin errors++; $display("FAIL ar_cnt k=%0d: got %0d expected %0d", k, cnt_out[7:0], exp_cnt); end
      checks++; if (intr[0] !== exp_int || int_any !== exp_int) begin
        errors++; $display("FAIL ar_int k=%0d: got %0b/%0b expected %0b", k, intr[0], int_any, exp_int);
      end
    end
    int_clr = 4'b0000;
    tick    = 1'b0;
    cfg_write(2'd0, 8'd0, 2'b00);
    checks++; if (cnt_out[7:0] !== 8'd0) begin errors++; $display("FAIL ar_disable_cnt: got %0d expected 0", cnt_out[7:0]); end
    checks++; if (intr[0] !== 1'b1) begin errors++; $display("FAIL ar_write_keeps_int: got %0b expected 1", intr[0]); end
    int_clr = 4'b0001;
    step();
    int_clr = 4'b0000;
    checks++; if (intr[0] !== 1'b0 || int_any !== 1'b0) begin errors++; $display("FAIL ar_clr: got %0b/%0b expected 0/0", intr[0], int_any); end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_cnt;
    logic       exp_int;
    cfg_write(2'd1, 8'd3, 2'b01);
    checks++; if (cnt_out[15:8] !== 8'd0) begin errors++; $display("FAIL os_start: got %0d expected 0", cnt_out[15:8]); end
    tick = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      exp_cnt = (k < 3) ? 8'(k) : 8'd3;
      exp_int = (k >= 4);
      checks++; if (cnt_out[15:8] !== exp_cnt) begin errors++; $display("FAIL os_cnt k=%0d: got %0d expected %0d", k, cnt_out[15:8], exp_cnt); end
      checks++; if (intr[1] !== exp_int || int_any !== exp_int) begin
        errors++; $display("FAIL os_int k=%0d: got %0b/%0b expected %0b", k, intr[1], int_any, exp_int);
      end
    end
    tick    = 1'b0;
    int_clr = 4'b0010;
    step();
    int_clr = 4'b0000;
    checks++; if (intr[1] !== 1'b0 || int_any !== 1'b0) begin errors++; $display("FAIL os_clr: got %0b/%0b expected 0/0", intr[1], int_any); end
    tick = 1'b1;
    for (int k = 0; k < 3; k++) step();
    tick = 1'b0;
    checks++; if (cnt_out[15:8] !== 8'd3 || intr[1] !== 1'b0) begin
      errors++; $display("FAIL os_done_hold: got cnt=%0d int=%0b expected 3/0", cnt_out[15:8], intr[1]);
    end
  endtask

  task automatic test_load_zero();
    cfg_write(2'd2, 8'd0, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      tick = (k % 2 == 1);
      step();
      checks++; if (cnt_out[23:16] !== 8'd0 || intr[2] !== 1'b1) begin
        errors++; $display("FAIL lz_ch2 k=%0d: got cnt=%0d int=%0b expected 0/1", k, cnt_out[23:16], intr[2]);
      end
    end
    tick = 1'b0;
    cfg_write(2'd3, 8'd7, 2'b11);
    tick = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (cnt_out[31:24] !== 8'd0 || intr[3] !== 1'b0) begin
      errors++; $display("FAIL lz_reserved: got cnt=%0d int=%0b expected 0/0", cnt_out[31:24], intr[3]);
    end
    tick = 1'b0;
    cfg_write(2'd2, 8'd0, 2'b00);
    int_clr = 4'b0100;
    step();
    int_clr = 4'b0000;
    checks++; if (intr !== 4'b0000 || int_any !== 1'b0) begin errors++; $display("FAIL lz_clr: got %0b/%0b expected 0/0", intr, int_any); end
  endtask

  task automatic test_collision();
    logic [7:0] exp_cnt;
    logic       exp_int;
    cfg_write(2'd0, 8'd5, 2'b10);
    tick = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (cnt_out[7:0] !== 8'd5) begin errors++; $display("FAIL col_pre: got %0d expected 5", cnt_out[7:0]); end
    cfg_write(2'd0, 8'd2, 2'b10);
    checks++; if (cnt_out[7:0] !== 8'd0 || intr[0] !== 1'b0) begin
      errors++; $display("FAIL col_suppress: got cnt=%0d int=%0b expected 0/0", cnt_out[7:0], intr[0]);
    end
    checks++; if (cnt_out[15:8] !== 8'd3) begin errors++; $display("FAIL col_ch1_undisturbed: got %0d expected 3", cnt_out[15:8]); end
    for (int k = 1; k <= 6; k++) begin
      int_clr = (k == 4 || k == 6) ? 4'b0001 : 4'b0000;
      step();
      exp_cnt = 8'(k % 3);
      exp_int = (k == 3) || (k == 6);
      checks++; if (cnt_out[7:0] !== exp_cnt) begin errors++; $display("FAIL col_cnt k=%0d: got %0d expected %0d", k, cnt_out[7:0], exp_cnt); end
      checks++; if (intr[0] !== exp_int) begin errors++; $display("FAIL col_int k=%0d: got %0b expected %0b", k, intr[0], exp_int); end
    end
    int_clr = 4'b0000;
    tick    = 1'b0;
    cfg_write(2'd0, 8'd0, 2'b00);
    int_clr = 4'b0001;
    step();
    int_clr = 4'b0000;
  endtask

  task automatic test_async_reset();
    cfg_write(2'd0, 8'd9, 2'b10);
    cfg_write(2'd2, 8'd0, 2'b10);
    tick = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++; if (cnt_out[7:0] !== 8'd3 || intr[2] !== 1'b1) begin
      errors++; $display("FAIL ares_pre: got cnt=%0d int2=%0b expected 3/1", cnt_out[7:0], intr[2]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt_out !== 32'd0 || intr !== 4'b0000 || int_any !== 1'b0) begin
      errors++; $display("FAIL ares_immediate: got cnt=%0h int=%0b any=%0b expected 0", cnt_out, intr, int_any);
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (cnt_out !== 32'd0 || intr !== 4'b0000) begin
        errors++; $display("FAIL ares_no_count k=%0d: got cnt=%0h int=%0b expected 0/0", k, cnt_out, intr);
      end
    end
    tick = 1'b0;
    cfg_write(2'd0, 8'd2, 2'b10);
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++; if (cnt_out[7:0] !== 8'd1) begin errors++; $display("FAIL ares_rewrite: got %0d expected 1", cnt_out[7:0]); end
  endtask

  task automatic test_width4();
    logic [3:0] exp_cnt;
    logic       exp_int;
    cfg_we4 = 1'b1; cfg_ch4 = 2'd0; cfg_load4 = 4'd15; cfg_mode4 = 2'b10;
    step();
    cfg_we4 = 1'b0;
    checks++; if (cnt_out4[3:0] !== 4'd0) begin errors++; $display("FAIL w4_start: got %0d expected 0", cnt_out4[3:0]); end
    tick4 = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      int_clr4 = (k == 17) ? 4'b0001 : 4'b0000;
      step();
      exp_cnt = 4'(k % 16);
      exp_int = (k == 16) || (k >= 32);
      checks++; if (cnt_out4[3:0] !== exp_cnt) begin errors++; $display("FAIL w4_cnt k=%0d: got %0d expected %0d", k, cnt_out4[3:0], exp_cnt); end
      checks++; if (intr4[0] !== exp_int || int_any4 !== exp_int) begin
        errors++; $display("FAIL w4_int k=%0d: got %0b/%0b expected %0b", k, intr4[0], int_any4, exp_int);
      end
    end
    tick4    = 1'b0;
    int_clr4 = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_load_zero();
    test_collision();
    test_async_reset();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
